fifo_win_reader: RTL and testbench
==================================

FIFO_WIN_READER -- requirements
Module: fifo_win_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width.
REQ-002 SHALL have parameter ADDR_W, default 8, per-bank address width.
REQ-003 SHALL have parameter NUM_OF_MEM, default 8, number of memory banks.
REQ-004 SHALL have parameter RD_LAT, default 2, cycles from r_en to valid bank data.
REQ-005 SHALL have parameter SKID_DEPTH, default 4, output buffer entries; legal range is SKID_DEPTH >= RD_LAT+1.
REQ-006 SHALL have the following ports; timing uses one clock, and reset is synchronous and active-high:
  clk  in  1  sole clock
  reset  in  1  synchronous active-high reset
  start_i  in  1  window request strobe
  bank_i  in  BANK_W  bank select, BANK_W=$clog2(NUM_OF_MEM)
  base_addr_i  in  ADDR_W  first read address
  len_i  in  ADDR_W+1  samples in window, 1..2^ADDR_W
  r_addr  out  ADDR_W*NUM_OF_MEM  packed per-bank read addresses
  r_en  out  NUM_OF_MEM  per-bank read enables
  mem_data_i  in  DATA_W*NUM_OF_MEM  packed bank outputs, signed
  sample_o  out  DATA_W  signed output sample
  sample_valid_o  out  1  sample_o valid
  sample_ready_i  in  1  consumer accepts sample
  last_o  out  1  final sample of window, qualified by sample_valid_o
  busy_o  out  1  window in progress
  done_o  out  1  one-cycle pulse after last sample accepted

Function
REQ-007 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-008 SHALL accept start_i only in IDLE with len_i != 0: latch bank, base, len, then enter ISSUE next cycle.
REQ-009 SHALL ignore start_i while busy_o=1, and SHALL ignore it in IDLE when len_i=0.
REQ-010 SHALL, in ISSUE, assert r_en[bank] for one cycle per read and only while credits > 0, where credits = SKID_DEPTH - (outstanding reads + buffered samples).
REQ-011 SHALL drive r_addr slice of selected bank with base+k mod 2^ADDR_W for read k (wrap 255->0 at ADDR_W=8); other slices hold 0, other r_en bits 0.
REQ-012 SHALL capture mem_data_i slice of the latched bank exactly RD_LAT cycles after each r_en into the skid buffer.
REQ-013 SHALL move from ISSUE to DRAIN in the cycle after the len-th read issues.
REQ-014 SHALL transfer a sample when sample_valid_o and sample_ready_i are both high; sample_o and last_o SHALL be held stable while valid and not ready.
REQ-015 SHALL move from DRAIN to IDLE and pulse done_o in the cycle after the last-flagged sample transfers.
REQ-016 SHALL achieve one sample per cycle sustained when sample_ready_i stays high; first sample_valid_o is RD_LAT+2 cycles after start_i.
REQ-017 SHALL assert busy_o in ISSUE and DRAIN only.
REQ-018 SHALL let a simultaneous buffer pop and capture in one cycle keep the count unchanged, with no loss.

Reset
REQ-019 SHALL, on reset, force IDLE, r_en=0, r_addr=0, sample_valid_o=0, last_o=0, busy_o=0, done_o=0, sample_o=0.
REQ-020 SHALL, on reset mid-window, discard in-flight reads and buffered samples; no sample SHALL appear after reset deasserts.

Configuration
REQ-021 SHALL, with FIFO_RD_BACKWARD_EN defined, add input dir_i (1 bit), latched at accepted start, where 1 selects addresses base-k mod 2^ADDR_W.
REQ-022 SHALL, without FIFO_RD_BACKWARD_EN, omit dir_i and read forward only.

Structure
REQ-023 SHALL place the state enum, BANK_W derivation and the default for SKID_DEPTH in shared package fifo_rd_pkg.
REQ-024 SHALL implement the output buffer as sub-module fifo_rd_skid, a synchronous FIFO SKID_DEPTH deep with push, pop, count.

Verification
REQ-025 SHALL verify that bank 3, base 0x10, len 4, ready=1 -> r_en[3] on 4 consecutive cycles with addresses 0x10..0x13, samples in order, last_o on 4th, done_o once.
REQ-026 SHALL verify that base 0xFE, len 4 -> addresses 0xFE,0xFF,0x00,0x01.
REQ-027 SHALL verify that len 8 with ready low after 2 samples for 10 cycles -> issue stalls at credits 0, no sample lost or duplicated, sample_o stable while stalled.
REQ-028 SHALL verify that start_i pulsed during busy and start_i with len 0 -> both ignored, no r_en activity.
REQ-029 SHALL verify that reset asserted 3 cycles into a len-16 window -> all outputs 0 next cycle, no valid afterwards, new window then runs correctly.
REQ-030 SHALL verify, with FIFO_RD_BACKWARD_EN defined, that dir_i=1, base 0x01, len 3 -> addresses 0x01,0x00,0xFF.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the windowed bank reader: FSM states, bank-select
// width derivation and the default output-buffer depth.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH_DEF = 4;

  function automatic int bank_w(input int num_of_mem);
    return (num_of_mem > 1) ? $clog2(num_of_mem) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Synchronous FIFO used as the reader's output buffer; accepts push and pop in
// the same cycle, including when full, so a pop frees the slot a push fills.
module fifo_rd_skid #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     pop_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) r_mem[r_wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (pop_i)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data_o = r_mem[r_rd_ptr];
  assign count_o    = r_count;

endmodule

// File: rtl/fifo_win_reader.sv
// Streams a window of samples out of one of NUM_OF_MEM fixed-latency banks with
// credit-based issue into an output FIFO. FIFO_RD_BACKWARD_EN adds dir_i (reverse reads).
module fifo_win_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int NUM_OF_MEM = 8,
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF,
  localparam int BANK_W    = bank_w(NUM_OF_MEM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic [BANK_W-1:0]            bank_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [ADDR_W:0]              len_i,
`ifdef FIFO_RD_BACKWARD_EN
  input  logic                         dir_i,
`endif
  output logic [ADDR_W*NUM_OF_MEM-1:0] r_addr,
  output logic [NUM_OF_MEM-1:0]        r_en,
  input  logic [DATA_W*NUM_OF_MEM-1:0] mem_data_i,
  output logic [DATA_W-1:0]            sample_o,
  output logic                         sample_valid_o,
  input  logic                         sample_ready_i,
  output logic                         last_o,
  output logic                         busy_o,
  output logic                         done_o,
  output rd_state_e                    state_o
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  rd_state_e         r_state;
  logic [BANK_W-1:0] r_bank;
  logic [ADDR_W-1:0] r_addr_cur;
  logic [ADDR_W:0]   r_remain;
  logic [RD_LAT-1:0] r_vpipe;
  logic [RD_LAT-1:0] r_lpipe;
  logic              r_done;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_outst;
  logic [CNT_W:0]    w_used;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_pop;
  logic [DATA_W:0]   w_pop_data;
  logic [DATA_W:0]   w_push_data;
  logic [ADDR_W-1:0] w_addr_next;

`ifdef FIFO_RD_BACKWARD_EN
  logic r_dir;
  assign w_addr_next = r_dir ? r_addr_cur - ADDR_W'(1) : r_addr_cur + ADDR_W'(1);
`else
  assign w_addr_next = r_addr_cur + ADDR_W'(1);
`endif

  // A sample popped this cycle no longer occupies a slot, so sustained
  // streaming fits in SKID_DEPTH = RD_LAT+1.
  always_comb begin
    w_outst = '0;
    for (int i = 0; i < RD_LAT; i++) w_outst = w_outst + (CNT_W + 1)'(r_vpipe[i]);
  end

  assign w_pop        = sample_valid_o & sample_ready_i;
  assign w_used       = w_outst + {1'b0, w_count} - (CNT_W + 1)'(w_pop);
  assign w_issue      = (r_state == ST_ISSUE) && (w_used < (CNT_W + 1)'(SKID_DEPTH));
  assign w_last_issue = w_issue && (r_remain == (ADDR_W + 1)'(1));

  always_comb begin
    r_en   = '0;
    r_addr = '0;
    if (w_issue) r_en[r_bank] = 1'b1;
    if (r_state == ST_ISSUE) r_addr[int'(r_bank)*ADDR_W +: ADDR_W] = r_addr_cur;
  end

  assign w_push_data = {r_lpipe[RD_LAT-1], mem_data_i[int'(r_bank)*DATA_W +: DATA_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bank     <= '0;
      r_addr_cur <= '0;
      r_remain   <= '0;
      r_vpipe    <= '0;
      r_lpipe    <= '0;
      r_done     <= 1'b0;
`ifdef FIFO_RD_BACKWARD_EN
      r_dir      <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_vpipe <= (r_vpipe << 1) | RD_LAT'(w_issue);
      r_lpipe <= (r_lpipe << 1) | RD_LAT'(w_last_issue);
      case (r_state)
        ST_IDLE: begin
          if (start_i && (len_i != '0)) begin
            r_bank     <= bank_i;
            r_addr_cur <= base_addr_i;
            r_remain   <= len_i;
`ifdef FIFO_RD_BACKWARD_EN
            r_dir      <= dir_i;
`endif
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_issue) begin
            r_addr_cur <= w_addr_next;
            r_remain   <= r_remain - (ADDR_W + 1)'(1);
            if (w_last_issue) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && last_o) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fifo_rd_skid #(
    .W     (DATA_W + 1),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (r_vpipe[RD_LAT-1]),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .pop_data_o  (w_pop_data),
    .count_o     (w_count)
  );

  assign sample_valid_o = (w_count != '0);
  assign sample_o       = sample_valid_o ? w_pop_data[DATA_W-1:0] : '0;
  assign last_o         = sample_valid_o & w_pop_data[DATA_W];
  assign busy_o         = (r_state != ST_IDLE);
  assign done_o         = r_done;
  assign state_o        = r_state;

endmodule

// File: tb/tb_fifo_win_reader.sv
// Bench for fifo_win_reader: banks are modelled as random-content arrays behind
// an RD_LAT pipeline; expected windows are built directly from base/len/dir.
`timescale 1ns/1ps
module tb_fifo_win_reader;
  import fifo_rd_pkg::*;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 8;
  localparam int NUM_OF_MEM = 8;
  localparam int RD_LAT     = 2;
  localparam int SKID_DEPTH = 4;
  localparam int BANK_W     = 3;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         start_i = 1'b0;
  logic [BANK_W-1:0]            bank_i = '0;
  logic [ADDR_W-1:0]            base_addr_i = '0;
  logic [ADDR_W:0]              len_i = '0;
`ifdef FIFO_RD_BACKWARD_EN
  logic                         dir_i = 1'b0;
`endif
  logic [ADDR_W*NUM_OF_MEM-1:0] r_addr;
  logic [NUM_OF_MEM-1:0]        r_en;
  logic [DATA_W*NUM_OF_MEM-1:0] mem_data_i;
  logic [DATA_W-1:0]            sample_o;
  logic                         sample_valid_o;
  logic                         sample_ready_i = 1'b1;
  logic                         last_o;
  logic                         busy_o;
  logic                         done_o;
  rd_state_e                    state_o;

  fifo_win_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_OF_MEM(NUM_OF_MEM),
    .RD_LAT(RD_LAT), .SKID_DEPTH(SKID_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .bank_i(bank_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
`ifdef FIFO_RD_BACKWARD_EN
    .dir_i(dir_i),
`endif
    .r_addr(r_addr), .r_en(r_en), .mem_data_i(mem_data_i),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i), .last_o(last_o), .busy_o(busy_o),
    .done_o(done_o), .state_o(state_o)
  );

  // ---------------- clock / reset / counters ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required summary");
    $fatal(1, "watchdog");
  end

  // ---------------- bank model ----------------
  logic [DATA_W-1:0]            mem_val [NUM_OF_MEM][256];
  logic [DATA_W*NUM_OF_MEM-1:0] mem_pipe [RD_LAT];

  always @(posedge clk) begin
    logic [DATA_W*NUM_OF_MEM-1:0] w;
    for (int b = 0; b < NUM_OF_MEM; b++)
      w[b*DATA_W +: DATA_W] = r_en[b] ? mem_val[b][r_addr[b*ADDR_W +: ADDR_W]] : DATA_W'($urandom);
    for (int i = RD_LAT - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
    mem_pipe[0] <= w;
  end
  assign mem_data_i = mem_pipe[RD_LAT-1];

  // ---------------- ready driver ----------------
  bit ready_rand  = 1'b0;
  bit ready_force = 1'b1;
  always @(posedge clk) begin
    #1;
    sample_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // ---------------- observation log ----------------
  logic [ADDR_W-1:0] obs_addr_q[$];
  int                obs_bank_q[$];
  int                obs_en_cyc_q[$];
  logic [DATA_W-1:0] obs_data_q[$];
  bit                obs_last_q[$];
  int                obs_pop_cyc_q[$];
  int done_cnt = 0, en_errs = 0, stable_errs = 0, valid_cnt = 0, first_valid_cyc = -1;
  bit                stall_prev = 1'b0;
  logic [DATA_W-1:0] held_d;
  logic              held_l;

  always @(negedge clk) begin
    int nb, bk;
    nb = 0; bk = 0;
    for (int b = 0; b < NUM_OF_MEM; b++) if (r_en[b]) begin nb++; bk = b; end
    if (nb > 0) begin
      if (nb > 1) en_errs++;
      for (int b = 0; b < NUM_OF_MEM; b++)
        if (b != bk && r_addr[b*ADDR_W +: ADDR_W] != '0) en_errs++;
      obs_addr_q.push_back(r_addr[bk*ADDR_W +: ADDR_W]);
      obs_bank_q.push_back(bk);
      obs_en_cyc_q.push_back(cyc);
    end
    if (sample_valid_o) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (sample_valid_o && sample_ready_i) begin
      obs_data_q.push_back(sample_o);
      obs_last_q.push_back(last_o);
      obs_pop_cyc_q.push_back(cyc);
    end
    if (done_o) done_cnt++;
    if (stall_prev && (sample_valid_o !== 1'b1 || sample_o !== held_d || last_o !== held_l)) stable_errs++;
    stall_prev = !reset && sample_valid_o && !sample_ready_i;
    held_d = sample_o;
    held_l = last_o;
  end

  // ---------------- reference model ----------------
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_q[$];

  task automatic build_model(input int bank, input int base, input int len, input bit dir);
    logic [ADDR_W-1:0] a;
    exp_addr_q.delete();
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      a = ADDR_W'(dir ? base - k : base + k);
      exp_addr_q.push_back(a);
      exp_q.push_back(mem_val[bank][a]);
    end
  endtask

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic clear_logs();
    obs_addr_q.delete(); obs_bank_q.delete(); obs_en_cyc_q.delete();
    obs_data_q.delete(); obs_last_q.delete(); obs_pop_cyc_q.delete();
    done_cnt = 0; en_errs = 0; stable_errs = 0; valid_cnt = 0; first_valid_cyc = -1;
  endtask

  task automatic start_window(input int bank, input int base, input int len, input bit dir);
    @(posedge clk); #1;
    start_i     = 1'b1;
    bank_i      = BANK_W'(bank);
    base_addr_i = ADDR_W'(base);
    len_i       = (ADDR_W + 1)'(len);
`ifdef FIFO_RD_BACKWARD_EN
    dir_i       = dir;
`endif
    start_cyc   = cyc;
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > 0) begin timed_out = 1'b0; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (r_en !== '0) begin n_err++; $display("FAIL reset_r_en: got %0h, required 0", r_en); end
    n_vec++; if (r_addr !== '0) begin n_err++; $display("FAIL reset_r_addr: got %0h, required 0", r_addr); end
    n_vec++; if (sample_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b, required 0", sample_valid_o); end
    n_vec++; if (last_o !== 1'b0) begin n_err++; $display("FAIL reset_last: got %0b, required 0", last_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b, required 0", busy_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b, required 0", done_o); end
    n_vec++; if (sample_o !== '0) begin n_err++; $display("FAIL reset_sample: got %0h, required 0", sample_o); end
    n_vec++; if (state_o !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", state_o, ST_IDLE); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    ready_rand = 1'b0; ready_force = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    build_model(3, 'h10, 4, 1'b0);
    start_window(3, 'h10, 4, 1'b0);
    wait_done(200, to);
    repeat (4) @(posedge clk);
    n_vec++; if (to) begin n_err++; $display("FAIL basic_timeout: got no done_o in 200 cycles, required done_o"); end
    n_vec++; if (obs_addr_q.size() !== 4) begin n_err++; $display("FAIL basic_reads: got %0d, required 4", obs_addr_q.size()); end
    for (int k = 0; k < 4 && k < obs_addr_q.size(); k++) begin
      n_vec++; if (obs_addr_q[k] !== exp_addr_q[k]) begin n_err++; $display("FAIL basic_addr[%0d]: got %0h, required %0h", k, obs_addr_q[k], exp_addr_q[k]); end
      n_vec++; if (obs_bank_q[k] !== 3) begin n_err++; $display("FAIL basic_bank[%0d]: got %0d, required 3", k, obs_bank_q[k]); end
    end
    if (obs_en_cyc_q.size() == 4) begin
      n_vec++; if (obs_en_cyc_q[3] - obs_en_cyc_q[0] !== 3) begin n_err++; $display("FAIL basic_en_span: got %0d, required 3", obs_en_cyc_q[3] - obs_en_cyc_q[0]); end
    end
    n_vec++; if (en_errs !== 0) begin n_err++; $display("FAIL basic_other_banks: got %0d bad cycles, required 0", en_errs); end
    n_vec++; if (obs_data_q.size() !== 4) begin n_err++; $display("FAIL basic_samples: got %0d, required 4", obs_data_q.size()); end
    for (int k = 0; k < 4 && k < obs_data_q.size(); k++) begin
      n_vec++; if (obs_data_q[k] !== exp_q[k]) begin n_err++; $display("FAIL basic_data[%0d]: got %0h, required %0h", k, obs_data_q[k], exp_q[k]); end
      n_vec++; if (obs_last_q[k] !== (k == 3)) begin n_err++; $display("FAIL basic_last[%0d]: got %0b, required %0b", k, obs_last_q[k], k == 3); end
    end
    if (obs_pop_cyc_q.size() == 4) begin
      n_vec++; if (obs_pop_cyc_q[3] - obs_pop_cyc_q[0] !== 3) begin n_err++; $display("FAIL basic_throughput: got span %0d, required 3", obs_pop_cyc_q[3] - obs_pop_cyc_q[0]); end
    end
    n_vec++; if (first_valid_cyc - start_cyc !== RD_LAT + 2) begin n_err++; $display("FAIL basic_latency: got %0d, required %0d", first_valid_cyc - start_cyc, RD_LAT + 2); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_wrap();
    bit to;
    int bank;
    bank = $urandom_range(0, NUM_OF_MEM - 1);
    ready_rand = 1'b1;
    clear_logs();
    build_model(bank, 'hFE, 4, 1'b0);
    start_window(bank, 'hFE, 4, 1'b0);
    wait_done(200, to);
    repeat (4) @(posedge clk);
    n_vec++; if (to) begin n_err++; $display("FAIL wrap_timeout: got no done_o in 200 cycles, required done_o"); end
    n_vec++; if (obs_addr_q.size() !== 4) begin n_err++; $display("FAIL wrap_reads: got %0d, required 4", obs_addr_q.size()); end
    for (int k = 0; k < 4 && k < obs_addr_q.size(); k++) begin
      n_vec++; if (obs_addr_q[k] !== exp_addr_q[k]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %0h, required %0h", k, obs_addr_q[k], exp_addr_q[k]); end
    end
    for (int k = 0; k < 4 && k < obs_data_q.size(); k++) begin
      n_vec++; if (obs_data_q[k] !== exp_q[k]) begin n_err++; $display("FAIL wrap_data[%0d]: got %0h, required %0h", k, obs_data_q[k], exp_q[k]); end
    end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL wrap_done_count: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_stall();
    bit to;
    int bank, base;
    bank = $urandom_range(0, NUM_OF_MEM - 1);
    base = $urandom_range(0, 255);
    ready_rand = 1'b0; ready_force = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    build_model(bank, base, 8, 1'b0);
    start_window(bank, base, 8, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (obs_data_q.size() >= 2) break;
    end
    ready_force = 1'b0;
    repeat (10) @(posedge clk);
    n_vec++; if (obs_data_q.size() !== 2) begin n_err++; $display("FAIL stall_pops: got %0d, required 2", obs_data_q.size()); end
    n_vec++; if (obs_addr_q.size() !== 2 + SKID_DEPTH) begin n_err++; $display("FAIL stall_issue_credit: got %0d reads, required %0d", obs_addr_q.size(), 2 + SKID_DEPTH); end
    ready_force = 1'b1;
    wait_done(200, to);
    repeat (4) @(posedge clk);
    n_vec++; if (to) begin n_err++; $display("FAIL stall_timeout: got no done_o in 200 cycles, required done_o"); end
    n_vec++; if (stable_errs !== 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable cycles, required 0", stable_errs); end
    n_vec++; if (obs_data_q.size() !== 8) begin n_err++; $display("FAIL stall_samples: got %0d, required 8", obs_data_q.size()); end
    for (int k = 0; k < 8 && k < obs_data_q.size(); k++) begin
      n_vec++; if (obs_data_q[k] !== exp_q[k]) begin n_err++; $display("FAIL stall_data[%0d]: got %0h, required %0h", k, obs_data_q[k], exp_q[k]); end
      n_vec++; if (obs_last_q[k] !== (k == 7)) begin n_err++; $display("FAIL stall_last[%0d]: got %0b, required %0b", k, obs_last_q[k], k == 7); end
    end
  endtask

  task automatic test_ignore();
    bit to;
    ready_rand = 1'b0; ready_force = 1'b1;
    clear_logs();
    start_window(2, 5, 0, 1'b0);
    repeat (8) @(posedge clk);
    n_vec++; if (obs_addr_q.size() !== 0) begin n_err++; $display("FAIL ignore_len0_reads: got %0d, required 0", obs_addr_q.size()); end
    @(negedge clk);
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ignore_len0_busy: got %0b, required 0", busy_o); end
    ready_force = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    build_model(1, 'h40, 6, 1'b0);
    start_window(1, 'h40, 6, 1'b0);
    repeat (2) @(posedge clk);
    start_window(5, 'h80, 9, 1'b0);
    repeat (3) @(posedge clk);
    ready_force = 1'b1;
    wait_done(200, to);
    repeat (12) @(posedge clk);
    n_vec++; if (to) begin n_err++; $display("FAIL ignore_timeout: got no done_o in 200 cycles, required done_o"); end
    n_vec++; if (obs_addr_q.size() !== 6) begin n_err++; $display("FAIL ignore_busy_reads: got %0d, required 6", obs_addr_q.size()); end
    for (int k = 0; k < 6 && k < obs_addr_q.size(); k++) begin
      n_vec++; if (obs_bank_q[k] !== 1 || obs_addr_q[k] !== exp_addr_q[k]) begin n_err++; $display("FAIL ignore_read[%0d]: got bank %0d addr %0h, required bank 1 addr %0h", k, obs_bank_q[k], obs_addr_q[k], exp_addr_q[k]); end
    end
    for (int k = 0; k < 6 && k < obs_data_q.size(); k++) begin
      n_vec++; if (obs_data_q[k] !== exp_q[k]) begin n_err++; $display("FAIL ignore_data[%0d]: got %0h, required %0h", k, obs_data_q[k], exp_q[k]); end
    end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int bank, base;
    ready_rand = 1'b0; ready_force = 1'b1;
    clear_logs();
    start_window(6, 'h30, 16, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_logs();
    @(negedge clk);
    n_vec++; if (r_en !== '0 || r_addr !== '0) begin n_err++; $display("FAIL midreset_reads: got r_en %0h r_addr %0h, required 0 0", r_en, r_addr); end
    n_vec++; if (sample_valid_o !== 1'b0 || sample_o !== '0 || last_o !== 1'b0) begin n_err++; $display("FAIL midreset_sample: got valid %0b data %0h last %0b, required 0 0 0", sample_valid_o, sample_o, last_o); end
    n_vec++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL midreset_status: got busy %0b done %0b, required 0 0", busy_o, done_o); end
    repeat (30) @(posedge clk);
    n_vec++; if (valid_cnt !== 0) begin n_err++; $display("FAIL midreset_no_valid: got %0d valid cycles, required 0", valid_cnt); end
    n_vec++; if (obs_addr_q.size() !== 0 || done_cnt !== 0) begin n_err++; $display("FAIL midreset_quiet: got %0d reads %0d done, required 0 0", obs_addr_q.size(), done_cnt); end
    bank = $urandom_range(0, NUM_OF_MEM - 1);
    base = $urandom_range(0, 255);
    clear_logs();
    build_model(bank, base, 5, 1'b0);
    start_window(bank, base, 5, 1'b0);
    wait_done(200, to);
    repeat (4) @(posedge clk);
    n_vec++; if (to) begin n_err++; $display("FAIL midreset_timeout: got no done_o in 200 cycles, required done_o"); end
    n_vec++; if (obs_data_q.size() !== 5) begin n_err++; $display("FAIL midreset_samples: got %0d, required 5", obs_data_q.size()); end
    for (int k = 0; k < 5 && k < obs_data_q.size(); k++) begin
      n_vec++; if (obs_data_q[k] !== exp_q[k]) begin n_err++; $display("FAIL midreset_data[%0d]: got %0h, required %0h", k, obs_data_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int bank, base, len;
    bit bad;
    ready_rand = 1'b1;
    for (int w = 0; w < 6; w++) begin
      bank = $urandom_range(0, NUM_OF_MEM - 1);
      base = $urandom_range(0, 255);
      len  = (w == 0) ? 256 : $urandom_range(1, 40);
      clear_logs();
      build_model(bank, base, len, 1'b0);
      start_window(bank, base, len, 1'b0);
      wait_done(4 * len + 100, to);
      repeat (4) @(posedge clk);
      n_vec++; if (to) begin n_err++; $display("FAIL rand%0d_timeout: got no done_o, required done_o", w); end
      n_vec++; if (obs_data_q.size() !== len || obs_addr_q.size() !== len) begin n_err++; $display("FAIL rand%0d_counts: got %0d samples %0d reads, required %0d", w, obs_data_q.size(), obs_addr_q.size(), len); end
      bad = 1'b0;
      for (int k = 0; k < len && k < obs_data_q.size() && k < obs_addr_q.size(); k++)
        if (obs_data_q[k] !== exp_q[k] || obs_addr_q[k] !== exp_addr_q[k] || obs_bank_q[k] !== bank || obs_last_q[k] !== (k == len - 1)) begin
          if (!bad) $display("FAIL rand%0d_item[%0d]: got data %0h addr %0h bank %0d last %0b, required %0h %0h %0d %0b", w, k, obs_data_q[k], obs_addr_q[k], obs_bank_q[k], obs_last_q[k], exp_q[k], exp_addr_q[k], bank, k == len - 1);
          bad = 1'b1;
        end
      n_vec++; if (bad) n_err++;
      n_vec++; if (stable_errs !== 0 || en_errs !== 0) begin n_err++; $display("FAIL rand%0d_protocol: got %0d unstable %0d bad r_en, required 0 0", w, stable_errs, en_errs); end
      n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL rand%0d_done_count: got %0d, required 1", w, done_cnt); end
    end
  endtask

`ifdef FIFO_RD_BACKWARD_EN
  task automatic test_backward();
    bit to;
    ready_rand = 1'b0; ready_force = 1'b1;
    clear_logs();
    build_model(4, 'h01, 3, 1'b1);
    start_window(4, 'h01, 3, 1'b1);
    wait_done(200, to);
    repeat (4) @(posedge clk);
    n_vec++; if (to) begin n_err++; $display("FAIL back_timeout: got no done_o in 200 cycles, required done_o"); end
    n_vec++; if (obs_addr_q.size() !== 3) begin n_err++; $display("FAIL back_reads: got %0d, required 3", obs_addr_q.size()); end
    for (int k = 0; k < 3 && k < obs_addr_q.size(); k++) begin
      n_vec++; if (obs_addr_q[k] !== exp_addr_q[k]) begin n_err++; $display("FAIL back_addr[%0d]: got %0h, required %0h", k, obs_addr_q[k], exp_addr_q[k]); end
    end
    for (int k = 0; k < 3 && k < obs_data_q.size(); k++) begin
      n_vec++; if (obs_data_q[k] !== exp_q[k]) begin n_err++; $display("FAIL back_data[%0d]: got %0h, required %0h", k, obs_data_q[k], exp_q[k]); end
    end
  endtask
`endif

  initial begin
    for (int b = 0; b < NUM_OF_MEM; b++)
      for (int a = 0; a < 256; a++) mem_val[b][a] = DATA_W'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_random();
`ifdef FIFO_RD_BACKWARD_EN
    test_backward();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
